// File: rtl/transform_addr_sequencer_if.sv
// Command/issue bus of the butterfly address sequencer: config and control
// from the command FSM, per-lane operand/twiddle addresses back out.
interface transform_addr_sequencer_if #(
   parameter int unsigned LOGN      = 15,
   parameter int unsigned NUM_LANES = 2,
   parameter int unsigned GAPW      = 5
);
   localparam int unsigned LW = $clog2(LOGN + 1);
   localparam int unsigned SW = $clog2(LOGN);

   logic                      start;
   logic                      is_dif;
   logic [LW-1:0]             log_n_cfg;
   logic [GAPW-1:0]           hazard_gap;
   logic                      hold;
   logic                      abort;

   logic                      ready;
   logic                      busy;
   logic                      out_valid;
   logic [NUM_LANES*LOGN-1:0] addr_a;
   logic [NUM_LANES*LOGN-1:0] addr_b;
   logic [NUM_LANES*LOGN-1:0] tw_idx;
   logic [SW-1:0]             stage;
   logic                      stage_last;
   logic                      done;
   logic                      cfg_err;

   modport master (
      output start, is_dif, log_n_cfg, hazard_gap, hold, abort,
      input  ready, busy, out_valid, addr_a, addr_b, tw_idx, stage, stage_last, done, cfg_err
   );

   modport slave (
      input  start, is_dif, log_n_cfg, hazard_gap, hold, abort,
      output ready, busy, out_valid, addr_a, addr_b, tw_idx, stage, stage_last, done, cfg_err
   );
endinterface

// File: rtl/transform_addr_sequencer.sv
// FFT/NTT loop controller: per-cycle butterfly operand pairs, twiddle indices and
// stage markers for NUM_LANES parallel butterflies, DIT or DIF, with inter-stage gap.
module transform_addr_sequencer #(
   parameter int unsigned LOGN      = 15,
   parameter int unsigned LOGN_MIN  = 12,
   parameter int unsigned NUM_LANES = 2,
   parameter int unsigned GAPW      = 5
) (
   input logic                      clk,
   input logic                      rst_n,
   transform_addr_sequencer_if.slave bus
);
   localparam int unsigned LW   = $clog2(LOGN + 1);
   localparam int unsigned SW   = $clog2(LOGN);
   localparam int unsigned LLOG = $clog2(NUM_LANES);
   localparam int unsigned VW   = NUM_LANES * LOGN;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_DONE} state_e;

   state_e           state_q;
   logic [LW-1:0]    logn_q;
   logic             dif_q;
   logic [GAPW-1:0]  gap_q;
   logic [GAPW-1:0]  gcnt_q;
   logic [SW-1:0]    stg_q;
   logic [LOGN-1:0]  cnt_q;
   logic             valid_q;
   logic             last_q;
   logic             done_q;
   logic             err_q;
   logic [VW-1:0]    a_q;
   logic [VW-1:0]    b_q;
   logic [VW-1:0]    tw_q;

   logic [LOGN-1:0]  cnt_last;
   logic             stage_end;
   logic             final_stage;
   logic             cfg_ok;
   logic [SW-1:0]    stg_d;
   logic [LOGN-1:0]  cnt_d;
   logic [3*VW-1:0]  nx_lanes;
   logic [3*VW-1:0]  st_lanes;

   // Last issue index of a stage: N/(2*NUM_LANES)-1 for N = 2**ln.
   function automatic logic [LOGN-1:0] cnt_last_f(input logic [LW-1:0] ln);
      return (LOGN'(1) << (ln - LW'(LLOG + 1))) - LOGN'(1);
   endfunction

   // Returns {tw, addr_b, addr_a} for issue c of stage s; shift/mask only.
   function automatic logic [3*VW-1:0] lane_calc(input logic [SW-1:0]   s,
                                                 input logic [LOGN-1:0] c,
                                                 input logic [LW-1:0]   ln,
                                                 input logic            dif);
      logic [LW-1:0]   mlog;
      logic [LW-1:0]   tlog;
      logic [LOGN-1:0] m;
      logic [LOGN-1:0] k;
      logic [LOGN-1:0] i;
      logic [LOGN-1:0] j;
      logic [LOGN-1:0] a;
      logic [VW-1:0]   va;
      logic [VW-1:0]   vb;
      logic [VW-1:0]   vt;
      va   = '0;
      vb   = '0;
      vt   = '0;
      mlog = dif ? (ln - LW'(1) - LW'(s)) : LW'(s);
      tlog = ln - LW'(1) - mlog;
      m    = LOGN'(1) << mlog;
      for (int unsigned l = 0; l < NUM_LANES; l++) begin
         k = (c << LLOG) | LOGN'(l);
         i = k >> tlog;
         j = k & ((LOGN'(1) << tlog) - LOGN'(1));
         a = (i << (tlog + LW'(1))) | j;
         va[l*LOGN +: LOGN] = a;
         vb[l*LOGN +: LOGN] = a | (LOGN'(1) << tlog);
         vt[l*LOGN +: LOGN] = m + i;
      end
      return {vt, vb, va};
   endfunction

   assign cnt_last = cnt_last_f(logn_q);
   assign cfg_ok   = (bus.log_n_cfg >= LW'(LOGN_MIN)) && (bus.log_n_cfg <= LW'(LOGN));

   // Candidate next issue: next count in stage, or first issue of the following stage.
   always_comb begin
      stage_end   = (cnt_q == cnt_last);
      final_stage = (LW'(stg_q) == logn_q - LW'(1));
      stg_d       = stg_q;
      cnt_d       = cnt_q + LOGN'(1);
      if (state_q == S_GAP || stage_end) begin
         stg_d = stg_q + SW'(1);
         cnt_d = '0;
      end
   end

   assign nx_lanes = lane_calc(stg_d, cnt_d, logn_q, dif_q);
   assign st_lanes = lane_calc('0, '0, bus.log_n_cfg, bus.is_dif);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         logn_q  <= '0;
         dif_q   <= 1'b0;
         gap_q   <= '0;
         gcnt_q  <= '0;
         stg_q   <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         tw_q    <= '0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         if (bus.abort) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (bus.start) begin
                     if (cfg_ok) begin
                        logn_q             <= bus.log_n_cfg;
                        dif_q              <= bus.is_dif;
                        gap_q              <= bus.hazard_gap;
                        stg_q              <= '0;
                        cnt_q              <= '0;
                        {tw_q, b_q, a_q}   <= st_lanes;
                        valid_q            <= 1'b1;
                        last_q             <= (cnt_last_f(bus.log_n_cfg) == '0);
                        state_q            <= S_RUN;
                     end else begin
                        err_q <= 1'b1;
                     end
                  end
               end
               S_RUN: begin
                  valid_q <= 1'b0;
                  last_q  <= 1'b0;
                  if (!bus.hold) begin
                     if (!stage_end || (!final_stage && gap_q == '0)) begin
                        stg_q            <= stg_d;
                        cnt_q            <= cnt_d;
                        {tw_q, b_q, a_q} <= nx_lanes;
                        valid_q          <= 1'b1;
                        last_q           <= (cnt_d == cnt_last);
                     end else if (final_stage) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                     end else begin
                        gcnt_q  <= gap_q - GAPW'(1);
                        state_q <= S_GAP;
                     end
                  end
               end
               S_GAP: begin
                  if (!bus.hold) begin
                     if (gcnt_q != '0) begin
                        gcnt_q <= gcnt_q - GAPW'(1);
                     end else begin
                        stg_q            <= stg_d;
                        cnt_q            <= cnt_d;
                        {tw_q, b_q, a_q} <= nx_lanes;
                        valid_q          <= 1'b1;
                        last_q           <= (cnt_d == cnt_last);
                        state_q          <= S_RUN;
                     end
                  end
               end
               S_DONE:  state_q <= S_IDLE;
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.ready      = (state_q == S_IDLE);
   assign bus.busy       = (state_q == S_RUN) || (state_q == S_GAP);
   assign bus.out_valid  = valid_q;
   assign bus.addr_a     = a_q;
   assign bus.addr_b     = b_q;
   assign bus.tw_idx     = tw_q;
   assign bus.stage      = stg_q;
   assign bus.stage_last = last_q;
   assign bus.done       = done_q;
   assign bus.cfg_err    = err_q;
endmodule

// File: tb/tb_transform_addr_sequencer.sv
// Scoreboard bench: two sequencers (1 and 2 lanes) share stimulus; expected issues
// are generated from the butterfly loop definitions when a start is accepted.
module tb_transform_addr_sequencer;
   localparam int unsigned LOGN     = 5;
   localparam int unsigned LOGN_MIN = 3;
   localparam int unsigned GAPW     = 3;
   localparam int unsigned LW       = $clog2(LOGN + 1);
   localparam int unsigned SW       = $clog2(LOGN);
   localparam int unsigned VW       = 2 * LOGN;

   typedef struct packed {
      logic [VW-1:0] a;
      logic [VW-1:0] b;
      logic [VW-1:0] tw;
      logic [SW-1:0] stage;
      logic          last;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic            is_dif = 1'b0;
   logic            hold = 1'b0;
   logic            abort = 1'b0;
   logic [LW-1:0]   log_n_cfg = '0;
   logic [GAPW-1:0] hazard_gap = '0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   transform_addr_sequencer_if #(.LOGN(LOGN), .NUM_LANES(1), .GAPW(GAPW)) if0 ();
   transform_addr_sequencer_if #(.LOGN(LOGN), .NUM_LANES(2), .GAPW(GAPW)) if1 ();

   assign if0.start = start;      assign if1.start = start;
   assign if0.is_dif = is_dif;    assign if1.is_dif = is_dif;
   assign if0.log_n_cfg = log_n_cfg;   assign if1.log_n_cfg = log_n_cfg;
   assign if0.hazard_gap = hazard_gap; assign if1.hazard_gap = hazard_gap;
   assign if0.hold = hold;        assign if1.hold = hold;
   assign if0.abort = abort;      assign if1.abort = abort;

   transform_addr_sequencer #(.LOGN(LOGN), .LOGN_MIN(LOGN_MIN), .NUM_LANES(1), .GAPW(GAPW)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(if0.slave));
   transform_addr_sequencer #(.LOGN(LOGN), .LOGN_MIN(LOGN_MIN), .NUM_LANES(2), .GAPW(GAPW)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(if1.slave));

   exp_t q0[$];
   exp_t q1[$];
   int   rem[2]   = '{0, 0};
   logic donex[2] = '{1'b0, 1'b0};
   logic errx[2]  = '{1'b0, 1'b0};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   function automatic int qsize(input int d);
      return (d == 0) ? q0.size() : q1.size();
   endfunction

   function automatic exp_t qpop(input int d);
      if (d == 0) return q0.pop_front();
      return q1.pop_front();
   endfunction

   function automatic void qflush(input int d);
      if (d == 0) q0.delete();
      else q1.delete();
   endfunction

   // Reference: enumerate butterflies k of each stage and group them NUM_LANES per issue.
   function automatic int gen_run(input int d, input int lanes, input int ln, input logic dif, input int gap);
      int n, cn, m, t, k, i, j, a;
      exp_t e;
      n  = 1 << ln;
      cn = n / (2 * lanes);
      for (int s = 0; s < ln; s++) begin
         m = dif ? (1 << (ln - 1 - s)) : (1 << s);
         t = n / (2 * m);
         for (int c = 0; c < cn; c++) begin
            e = '0;
            for (int l = 0; l < lanes; l++) begin
               k = c * lanes + l;
               i = k / t;
               j = k % t;
               a = i * 2 * t + j;
               e.a[l*LOGN +: LOGN]  = LOGN'(a);
               e.b[l*LOGN +: LOGN]  = LOGN'(a + t);
               e.tw[l*LOGN +: LOGN] = LOGN'(m + i);
            end
            e.stage = SW'(s);
            e.last  = (c == cn - 1);
            if (d == 0) q0.push_back(e);
            else q1.push_back(e);
         end
      end
      // busy edges from the start edge up to the edge entering DONE
      return ln * cn + (ln - 1) * gap;
   endfunction

   task automatic model_step(input int d, input int lanes, input logic ready, input logic busy,
                             input logic valid, input logic done, input logic err, input exp_t got);
      logic dn;
      logic en;
      if (!rst_n) begin
         rem[d] = 0; donex[d] = 1'b0; errx[d] = 1'b0;
         qflush(d);
         return;
      end
      chk($sformatf("dut%0d ready", d), 64'(ready), 64'(rem[d] == 0 && !donex[d]));
      chk($sformatf("dut%0d busy", d), 64'(busy), 64'(rem[d] > 0));
      chk($sformatf("dut%0d done", d), 64'(done), 64'(donex[d]));
      chk($sformatf("dut%0d cfg_err", d), 64'(err), 64'(errx[d]));
      chk($sformatf("dut%0d done with out_valid", d), 64'(done && valid), 64'(0));
      if (valid) begin
         if (qsize(d) == 0) begin
            checks++; errors++;
            $display("FAIL dut%0d unexpected issue: got %0h expected none", d, got);
         end else begin
            chk($sformatf("dut%0d issue", d), 64'(got), 64'(qpop(d)));
         end
      end
      if (donex[d]) chk($sformatf("dut%0d issues left at done", d), 64'(qsize(d)), 64'(0));
      dn = 1'b0;
      en = 1'b0;
      if (abort) begin
         rem[d] = 0;
         qflush(d);
      end else if (rem[d] > 0) begin
         if (!hold) begin
            rem[d]--;
            if (rem[d] == 0) dn = 1'b1;
         end
      end else if (!donex[d] && start) begin
         if (int'(log_n_cfg) >= int'(LOGN_MIN) && int'(log_n_cfg) <= int'(LOGN))
            rem[d] = gen_run(d, lanes, int'(log_n_cfg), is_dif, int'(hazard_gap));
         else
            en = 1'b1;
      end
      donex[d] = dn;
      errx[d]  = en;
   endtask

   exp_t g0;
   exp_t g1;
   always @(negedge clk) begin
      g0 = '0;
      g0.a = VW'(if0.addr_a); g0.b = VW'(if0.addr_b); g0.tw = VW'(if0.tw_idx);
      g0.stage = if0.stage; g0.last = if0.stage_last;
      model_step(0, 1, if0.ready, if0.busy, if0.out_valid, if0.done, if0.cfg_err, g0);
   end

   always @(negedge clk) begin
      g1 = '0;
      g1.a = if1.addr_a; g1.b = if1.addr_b; g1.tw = if1.tw_idx;
      g1.stage = if1.stage; g1.last = if1.stage_last;
      model_step(1, 2, if1.ready, if1.busy, if1.out_valid, if1.done, if1.cfg_err, g1);
   end

   function automatic logic idle_all();
      return rem[0] == 0 && !donex[0] && rem[1] == 0 && !donex[1];
   endfunction

   task automatic chk_reset_outputs();
      chk("dut0 reset flags", 64'({if0.ready, if0.busy, if0.out_valid, if0.done, if0.cfg_err,
                                   if0.stage_last, if0.stage}), 64'(9'h100));
      chk("dut0 reset addr", 64'({if0.addr_a, if0.addr_b, if0.tw_idx}), 64'(0));
      chk("dut1 reset flags", 64'({if1.ready, if1.busy, if1.out_valid, if1.done, if1.cfg_err,
                                   if1.stage_last, if1.stage}), 64'(9'h100));
      chk("dut1 reset addr", 64'({if1.addr_a, if1.addr_b, if1.tw_idx}), 64'(0));
   endtask

   task automatic kick(input int ln, input logic dif, input int gap);
      @(posedge clk); #1;
      log_n_cfg  = LW'(ln);
      is_dif     = dif;
      hazard_gap = GAPW'(gap);
      start      = 1'b1;
      @(posedge clk); #1;
      start      = 1'b0;
      log_n_cfg  = LW'($urandom_range(0, 7));
      is_dif     = 1'($urandom_range(0, 1));
      hazard_gap = GAPW'($urandom_range(0, 7));
   endtask

   // Holds: random percentage plus two directed 3-cycle windows.
   task automatic run(input int ln, input logic dif, input int gap, input int hold_pct,
                      input int h1, input int h2, input int abort_at, input int restart_at);
      int n;
      kick(ln, dif, gap);
      for (n = 0; n < 3000; n++) begin
         if (idle_all()) break;
         hold  = ($urandom_range(0, 99) < hold_pct) ||
                 (n >= h1 && n < h1 + 3) || (n >= h2 && n < h2 + 3);
         abort = (n == abort_at);
         start = (n == restart_at);
         @(posedge clk); #1;
      end
      hold = 1'b0; abort = 1'b0; start = 1'b0;
      if (n >= 3000) begin
         checks++; errors++;
         $display("FAIL run timeout: got busy expected idle within 3000 cycles");
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: got no finish expected finish before 600000");
      $fatal(1);
   end

   initial begin
      #12;
      chk_reset_outputs();
      @(posedge clk); #1;
      rst_n = 1'b1;

      run(3, 1'b0, 0, 0, -1, -1, -1, -1);
      run(3, 1'b1, 2, 0, -1, -1, -1, -1);
      run(3, 1'b0, 0, 0, -1, -1, -1, -1);
      run(2, 1'b0, 1, 0, -1, -1, -1, -1);
      run(5, 1'b0, 3, 0, -1, -1, -1, -1);
      run(6, 1'b1, 1, 0, -1, -1, -1, -1);
      run(3, 1'b1, 4, 0, 1, 8, -1, -1);
      run(3, 1'b0, 0, 0, 2, -1, -1, 5);
      run(4, 1'b0, 1, 0, -1, -1, 10, -1);
      run(4, 1'b1, 0, 0, -1, -1, -1, -1);

      kick(4, 1'b1, 1);
      repeat (7) begin @(posedge clk); #1; end
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs();
      @(posedge clk); #1;
      rst_n = 1'b1;
      run(3, 1'b1, 1, 0, -1, -1, -1, -1);

      for (int r = 0; r < 30; r++) begin
         run($urandom_range(2, 6), 1'($urandom_range(0, 1)), $urandom_range(0, 7),
             ($urandom_range(0, 1) == 1) ? 15 : 0, -1, -1,
             ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : -1,
             ($urandom_range(0, 3) == 0) ? $urandom_range(0, 30) : -1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
